// File: rtl/cone_bist_ctrl.sv
// BIST controller for a single-output combinational cone. It applies N_PAT
// LFSR vectors, compacts the responses in a 16-bit MISR and compares the result to golden.
module cone_bist_ctrl #(
  parameter int unsigned      VEC_W  = 14,
  parameter int unsigned      N_PAT  = 256,
  parameter int unsigned      SETTLE = 2,
  parameter logic [VEC_W-1:0] SEED   = 14'h0001
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_in,
  input  logic [15:0]      golden,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [15:0]      pat_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    CAPTURE,
    DONE
  } state_e;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [VEC_W-1:0] SEED_EFF    = (SEED == '0) ? VEC_W'(1) : SEED;
  localparam logic [15:0]      LAST_PAT    = 16'(N_PAT - 1);
  localparam logic [3:0]       LAST_SETTLE = 4'(SETTLE - 1);

  state_e           state_q;
  logic [VEC_W-1:0] lfsr_q, lfsr_d;
  logic [VEC_W-1:0] vec_q;
  logic [15:0]      misr_q, misr_d;
  logic [15:0]      pat_cnt_q;
  logic [3:0]       settle_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    lfsr_d = {lfsr_q[VEC_W-2:0], lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[11] ^ lfsr_q[1]};
    misr_d = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10] ^ resp_in};
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_EFF;
      vec_q     <= '0;
      misr_q    <= '0;
      pat_cnt_q <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort) begin
      // The signature is deliberately left intact for post-mortem inspection.
      state_q   <= IDLE;
      vec_q     <= '0;
      pat_cnt_q <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        LOAD: begin
          lfsr_q    <= SEED_EFF;
          vec_q     <= SEED_EFF;
          misr_q    <= '0;
          pat_cnt_q <= '0;
          settle_q  <= '0;
          state_q   <= APPLY;
        end
        APPLY: begin
          if (settle_q == LAST_SETTLE) begin
            settle_q <= '0;
            state_q  <= CAPTURE;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        CAPTURE: begin
          misr_q    <= misr_d;
          lfsr_q    <= lfsr_d;
          vec_q     <= lfsr_d;
          pat_cnt_q <= pat_cnt_q + 16'd1;
          if (pat_cnt_q == LAST_PAT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= APPLY;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // Golden may change at any time in DONE, so the compare is not registered.
  assign pass      = done_q && (misr_q == golden);
  assign signature = misr_q;
  assign pat_cnt   = pat_cnt_q;

endmodule
